// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter with a valid/ready load port and frame start/done strobes.
// Define PISO_PARITY_EN to append an even-parity bit after the last data bit of every frame.
`timescale 1ns/1ps
module piso_shift_tx #(
   parameter int   WIDTH      = 4,
   parameter int   MSB_FIRST  = 1,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] par_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             frame_start,
   output logic             frame_done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_e;
`endif

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             serialOut_q, serialOut_d;
   logic             lastData;
   logic             finalCycle;
   logic             accept;
`ifdef PISO_PARITY_EN
   logic             parity_q, parity_d;
`endif

   function automatic logic headBit(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
   endfunction

   // Remaining bits after the head, aligned so the next one is again at the head position.
   function automatic logic [WIDTH-1:0] tailBits(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   assign lastData = (state_q == SHIFT) && (cnt_q == LAST);
`ifdef PISO_PARITY_EN
   assign finalCycle = (state_q == PARITY);
`else
   assign finalCycle = lastData;
`endif

   assign load_ready   = (state_q == IDLE) || finalCycle;
   assign accept       = load_valid && load_ready;
   assign serial_out   = serialOut_q;
   assign serial_valid = (state_q != IDLE);
   assign frame_start  = (state_q == SHIFT) && (cnt_q == '0);
   assign frame_done   = finalCycle;

   // Next-state: an accept always wins, which is what makes back-to-back frames gapless.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      serialOut_d = serialOut_q;
`ifdef PISO_PARITY_EN
      parity_d    = parity_q;
`endif
      if (accept) begin
         state_d     = SHIFT;
         shift_d     = tailBits(par_in);
         cnt_d       = '0;
         serialOut_d = headBit(par_in);
`ifdef PISO_PARITY_EN
         parity_d    = ^par_in;
`endif
      end else if ((state_q == SHIFT) && !lastData) begin
         cnt_d       = cnt_q + CW'(1);
         shift_d     = tailBits(shift_q);
         serialOut_d = headBit(shift_q);
      end else if (lastData) begin
`ifdef PISO_PARITY_EN
         state_d     = PARITY;
         serialOut_d = parity_q;
`else
         state_d     = IDLE;
         serialOut_d = IDLE_LEVEL;
`endif
      end
`ifdef PISO_PARITY_EN
      else if (state_q == PARITY) begin
         state_d     = IDLE;
         serialOut_d = IDLE_LEVEL;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         serialOut_q <= IDLE_LEVEL;
`ifdef PISO_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         serialOut_q <= serialOut_d;
`ifdef PISO_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a queue-based model of the expected serial stream.
`timescale 1ns/1ps
module tb_piso_shift_tx;

   localparam int   WIDTH      = 4;
   localparam int   MSB_FIRST  = 1;
   localparam logic IDLE_LEVEL = 1'b0;
`ifdef PISO_PARITY_EN
   localparam int   PAR        = 1;
`else
   localparam int   PAR        = 0;
`endif

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] parIn;
   logic             loadValid;
   logic             loadReady;
   logic             serialOut;
   logic             serialValid;
   logic             frameStart;
   logic             frameDone;
   logic [4:0]       obs;

   int vectors    = 0;
   int miscompares = 0;

   // Each entry is one upcoming frame cycle: {bit, start, done}; entry 0 is the current cycle.
   logic [2:0] expQ[$];

   piso_shift_tx #(
      .WIDTH      (WIDTH),
      .MSB_FIRST  (MSB_FIRST),
      .IDLE_LEVEL (IDLE_LEVEL)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .par_in       (parIn),
      .load_valid   (loadValid),
      .load_ready   (loadReady),
      .serial_out   (serialOut),
      .serial_valid (serialValid),
      .frame_start  (frameStart),
      .frame_done   (frameDone)
   );

   assign obs = {loadReady, serialValid, serialOut, frameStart, frameDone};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] expVec();
      if (expQ.size() == 0) return {1'b1, 1'b0, IDLE_LEVEL, 2'b00};
      return {(expQ.size() <= 1), 1'b1, expQ[0]};
   endfunction

   function automatic void pushWord(input logic [WIDTH-1:0] w);
      for (int i = 0; i < WIDTH; i++) begin
         int idx;
         idx = (MSB_FIRST != 0) ? (WIDTH - 1 - i) : i;
         expQ.push_back({w[idx], (i == 0), ((i == WIDTH - 1) && (PAR == 0))});
      end
      if (PAR != 0) expQ.push_back({^w, 1'b0, 1'b1});
   endfunction

   // Advances one clock and moves the model forward using the inputs held across that edge.
   task automatic tick();
      logic             acc;
      logic             r;
      logic [WIDTH-1:0] w;
      acc = loadValid && (expQ.size() <= 1) && !rst;
      r   = rst;
      w   = parIn;
      @(posedge clk);
      if (r) begin
         expQ.delete();
      end else begin
         if (expQ.size() > 0) void'(expQ.pop_front());
         if (acc) pushWord(w);
      end
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
      loadValid = v;
      parIn     = d;
      rst       = r;
   endtask

   task automatic test_reset();
      applyStimulus(1'b0, '0, 1'b1);
      tick();
      tick();
      vectors++;
      if (obs !== 5'b10000) begin
         miscompares++;
         $display("[TB] FAIL reset_state: got %b expected %b", obs, 5'b10000);
      end
      vectors++;
      if (obs !== expVec()) begin
         miscompares++;
         $display("[TB] FAIL reset_model: got %b expected %b", obs, expVec());
      end
      applyStimulus(1'b0, '0, 1'b0);
      tick();
   endtask

   task automatic test_single_frame();
      logic [WIDTH-1:0] sipo;
      int               nb;
      sipo = '0;
      nb   = 0;
      for (int c = 0; c < 9; c++) begin
         vectors++;
         if (obs !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL single c%0d: got %b expected %b", c, obs, expVec());
         end
         if (serialValid && nb < WIDTH) begin
            sipo = {sipo[WIDTH-2:0], serialOut};
            nb++;
         end
         applyStimulus(c == 0, (c == 0) ? 4'b1011 : 4'($urandom), 1'b0);
         tick();
      end
      vectors++;
      if (sipo !== 4'b1011) begin
         miscompares++;
         $display("[TB] FAIL single_sipo: got %b expected %b", sipo, 4'b1011);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] stream;
      int          nValid, nStart, nDone;
      stream = '0;
      nValid = 0;
      nStart = 0;
      nDone  = 0;
      for (int c = 0; c < 14; c++) begin
         vectors++;
         if (obs !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL b2b c%0d: got %b expected %b", c, obs, expVec());
         end
         if (serialValid) begin
            stream = {stream[14:0], serialOut};
            nValid++;
         end
         nStart += int'(frameStart);
         nDone  += int'(frameDone);
         if (c == 0)                applyStimulus(1'b1, 4'b1011, 1'b0);
         else if (c == WIDTH + PAR) applyStimulus(1'b1, 4'b0110, 1'b0);
         else                       applyStimulus(1'b0, 4'($urandom), 1'b0);
         tick();
      end
      vectors++;
      if (nValid != 2 * (WIDTH + PAR) || nStart != 2 || nDone != 2) begin
         miscompares++;
         $display("[TB] FAIL b2b_counts: got valid=%0d start=%0d done=%0d expected valid=%0d start=2 done=2",
                  nValid, nStart, nDone, 2 * (WIDTH + PAR));
      end
      vectors++;
      if (PAR == 0 && stream[7:0] !== 8'b10110110) begin
         miscompares++;
         $display("[TB] FAIL b2b_stream: got %b expected %b", stream[7:0], 8'b10110110);
      end
   endtask

   task automatic test_busy_load();
      logic [WIDTH-1:0] sipo;
      int               nb;
      sipo = '0;
      nb   = 0;
      for (int c = 0; c < 9; c++) begin
         vectors++;
         if (obs !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL busy c%0d: got %b expected %b", c, obs, expVec());
         end
         if (serialValid) begin
            if (nb < WIDTH) sipo = {sipo[WIDTH-2:0], serialOut};
            nb++;
         end
         if (c == 0)      applyStimulus(1'b1, 4'b1011, 1'b0);
         else if (c == 2) applyStimulus(1'b1, 4'b0000, 1'b0);
         else             applyStimulus(1'b0, 4'b0000, 1'b0);
         tick();
      end
      vectors++;
      if (sipo !== 4'b1011 || nb != WIDTH + PAR) begin
         miscompares++;
         $display("[TB] FAIL busy_stream: got %b/%0d bits expected %b/%0d bits", sipo, nb, 4'b1011, WIDTH + PAR);
      end
   endtask

   task automatic test_mid_reset();
      logic [WIDTH-1:0] sipo;
      int               nb, nDone;
      sipo  = '0;
      nb    = 0;
      nDone = 0;
      for (int c = 0; c < 12; c++) begin
         vectors++;
         if (obs !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL midrst c%0d: got %b expected %b", c, obs, expVec());
         end
         if (c == 3) begin
            vectors++;
            if (obs !== 5'b10000) begin
               miscompares++;
               $display("[TB] FAIL midrst_abort: got %b expected %b", obs, 5'b10000);
            end
         end
         if (serialValid && c >= 4 && nb < WIDTH) begin
            sipo = {sipo[WIDTH-2:0], serialOut};
            nb++;
         end
         nDone += int'(frameDone);
         if (c == 0)      applyStimulus(1'b1, 4'b1011, 1'b0);
         else if (c == 2) applyStimulus(1'b1, 4'b1111, 1'b1);
         else if (c == 4) applyStimulus(1'b1, 4'b0101, 1'b0);
         else             applyStimulus(1'b0, 4'($urandom), 1'b0);
         tick();
      end
      vectors++;
      if (sipo !== 4'b0101 || nDone != 1) begin
         miscompares++;
         $display("[TB] FAIL midrst_reload: got %b done=%0d expected %b done=1", sipo, nDone, 4'b0101);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         vectors++;
         if (obs !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL random c%0d: got %b expected %b", c, obs, expVec());
         end
         applyStimulus($urandom_range(0, 2) != 0, 4'($urandom), $urandom_range(0, 39) == 0);
         tick();
      end
      applyStimulus(1'b0, '0, 1'b0);
      for (int c = 0; c < WIDTH + 2; c++) begin
         vectors++;
         if (obs !== expVec()) begin
            miscompares++;
            $display("[TB] FAIL random_drain c%0d: got %b expected %b", c, obs, expVec());
         end
         tick();
      end
   endtask

   initial begin
      applyStimulus(1'b0, '0, 1'b1);
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_busy_load();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
